// File: rtl/uart_tx_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_packetizer                                           |
// | Description : Packs serial readback bits MSB-first into bytes, buffers     |
// |               them in a byte FIFO and emits framed packets                 |
// |               (HEADER, LEN, payload, XOR checksum) through an              |
// |               async_transmitter start/data/busy handshake.                 |
// | Ports       : clk_100    - system clock (only clock)                       |
// |               Reset      - asynchronous active-high reset                  |
// |               bit_valid  - bit_in is sampled this cycle                    |
// |               bit_in     - serial readback data bit                        |
// |               flush      - one-cycle request to send buffered data now     |
// |               tx_busy    - TxD_busy from the transmitter                   |
// |               tx_start   - one-cycle TxD_start pulse                       |
// |               tx_data    - TxD_data, held from tx_start to byte end        |
// |               fifo_count - bytes currently buffered                        |
// |               overflow   - sticky: a byte was dropped on a full FIFO       |
// |               sending    - a packet is in progress                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_packetizer #(
  parameter int         MAX_PAYLOAD = 16,
  parameter int         FIFO_DEPTH  = 32,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic                          clk_100,
  input  logic                          Reset,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  input  logic                          flush,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          sending
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_MAX_CNT   = c_CW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_SEND    = 2'd0,
    PH_WAIT_HI = 2'd1,
    PH_WAIT_LO = 2'd2
  } phase_t;

  state_t            r_state;
  phase_t            r_phase;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_flush_pending;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [7:0]        r_len;
  logic [7:0]        r_remaining;
  logic [7:0]        r_csum;

  logic [7:0]        w_shift_next;
  logic [3:0]        w_bits;
  logic              w_push;
  logic [7:0]        w_push_byte;
  logic              w_flush_set;
  logic              w_full;
  logic              w_pop;
  logic              w_wr_en;
  logic [c_CW-1:0]   w_len_cnt;
  logic              w_launch;
  logic              w_launch_clear;
  logic [7:0]        w_rd_byte;

  // Packer: the incoming bit (if any) is shifted in before a flush pads the
  // partial byte, so a flush on the 8th bit yields one full byte and no pad.
  always_comb begin
    w_shift_next = bit_valid ? {r_shift[6:0], bit_in} : r_shift;
    w_bits       = bit_valid ? ({1'b0, r_bit_cnt} + 4'd1) : {1'b0, r_bit_cnt};
    w_push       = 1'b0;
    w_push_byte  = w_shift_next;
    if (w_bits == 4'd8) begin
      w_push = 1'b1;
    end else if (flush && (w_bits != 4'd0)) begin
      // Left-justify the received bits; unfilled LSBs become 0.
      w_push      = 1'b1;
      w_push_byte = w_shift_next << (4'd8 - w_bits);
    end
  end

  // A flush with nothing packed and nothing buffered has no effect.
  assign w_flush_set = flush && (w_push || (fifo_count != '0));

  assign w_full    = (fifo_count == c_DEPTH_CNT);
  assign w_pop     = (r_state == ST_DATA) && (r_phase == PH_SEND) && !tx_busy;
  // A simultaneous pop frees a slot, so a push into a full FIFO is still taken.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_rd_byte = r_mem[r_rd_ptr];

  assign w_len_cnt = (fifo_count >= c_MAX_CNT) ? c_MAX_CNT : fifo_count;
  assign w_launch  = (r_state == ST_IDLE) &&
                     ((fifo_count >= c_MAX_CNT) ||
                      (r_flush_pending && (fifo_count != '0)));
  // Pending survives a launch that leaves bytes behind, giving back-to-back packets.
  assign w_launch_clear = w_launch && (w_len_cnt == fifo_count);

  always_ff @(posedge clk_100 or posedge Reset) begin
    if (Reset) begin
      r_shift         <= 8'd0;
      r_bit_cnt       <= 3'd0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_push) begin
        r_shift   <= 8'd0;
        r_bit_cnt <= 3'd0;
      end else begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= w_bits[2:0];
      end
      // A new flush wins over a launch-time clear: its byte is not in LEN.
      if (w_flush_set) begin
        r_flush_pending <= 1'b1;
      end else if (w_launch_clear) begin
        r_flush_pending <= 1'b0;
      end
    end
  end

  // FIFO storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk_100) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_byte;
    end
  end

  always_ff @(posedge clk_100 or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (w_push && !w_wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  // Packet sequencer with per-byte SEND / WAIT_HI / WAIT_LO handshake.
  always_ff @(posedge clk_100 or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= PH_SEND;
      r_len       <= 8'd0;
      r_remaining <= 8'd0;
      r_csum      <= 8'd0;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      sending     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_launch) begin
          r_len       <= 8'(w_len_cnt);
          r_remaining <= 8'(w_len_cnt);
          r_state     <= ST_HDR;
          r_phase     <= PH_SEND;
          sending     <= 1'b1;
        end
      end else begin
        case (r_phase)
          PH_SEND: begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              r_phase  <= PH_WAIT_HI;
              case (r_state)
                ST_HDR: tx_data <= HEADER;
                ST_LEN: begin
                  tx_data <= r_len;
                  r_csum  <= r_len;
                end
                ST_DATA: begin
                  tx_data     <= w_rd_byte;
                  r_csum      <= r_csum ^ w_rd_byte;
                  r_remaining <= r_remaining - 8'd1;
                end
                ST_CSUM: tx_data <= r_csum;
                default: tx_data <= tx_data;
              endcase
            end
          end
          PH_WAIT_HI: begin
            if (tx_busy) begin
              r_phase <= PH_WAIT_LO;
            end
          end
          PH_WAIT_LO: begin
            if (!tx_busy) begin
              r_phase <= PH_SEND;
              case (r_state)
                ST_HDR:  r_state <= ST_LEN;
                ST_LEN:  r_state <= ST_DATA;
                ST_DATA: begin
                  if (r_remaining == 8'd0) begin
                    r_state <= ST_CSUM;
                  end
                end
                ST_CSUM: begin
                  r_state <= ST_IDLE;
                  sending <= 1'b0;
                end
                default: r_state <= ST_IDLE;
              endcase
            end
          end
          default: r_phase <= PH_SEND;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
